// File: rtl/adc_spi_sampler_pkg.sv
// Shared types and frame constants for the MCP3002-style SPI ADC sampler.
package adc_spi_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    DONE
  } state_t;

  localparam int FRAME_LEN      = 16;
  localparam int DATA_W         = 10;
  localparam int EDGE_W         = 5;
  localparam int FIRST_DATA_BIT = 7;
  localparam int LAST_DATA_BIT  = 16;

  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  // Frame bits are numbered 1..FRAME_LEN; anything past the command nibble is zero.
  function automatic logic frame_bit(input logic [EDGE_W-1:0] idx, input logic ch);
    logic b;
    case (idx)
      EDGE_W'(1): b = CMD_START;
      EDGE_W'(2): b = CMD_SGL;
      EDGE_W'(3): b = ch;
      EDGE_W'(4): b = CMD_MSBF;
      default:    b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// Half-period timer for the SPI clock; strobes mark the sysclk edge on which SCK rises or falls.
module adc_sck_gen #(
  parameter int SCK_DIV = 25
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic run,
  input  logic toggle,
  output logic tick,
  output logic rise_en,
  output logic fall_en
);

  localparam int CW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;

  logic [CW-1:0] half_cnt;
  logic          phase;

  assign tick    = run && (half_cnt == CW'(SCK_DIV - 1));
  assign rise_en = tick && toggle && !phase;
  assign fall_en = tick && toggle && phase;

  // The counter restarts whenever the FSM idles, so every phase starts on a full half-period.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      if (!run || tick) half_cnt <= '0;
      else              half_cnt <= half_cnt + 1'b1;

      if (!toggle)   phase <= 1'b0;
      else if (tick) phase <= ~phase;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Runs one 16-bit SPI frame per start request and publishes the 10-bit conversion result.
module adc_spi_sampler
  import adc_spi_sampler_pkg::*;
#(
  parameter int SCK_DIV = 25
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              channel,
  output logic              adc_cs,
  output logic              adc_sck,
  output logic              adc_mosi,
  input  logic              adc_miso,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  state_t              state, state_next;
  logic                ch_latched;
  logic [EDGE_W-1:0]   rise_cnt;
  logic [EDGE_W-1:0]   rise_next;
  logic [DATA_W-1:0]   shreg;
  logic                sck_run, sck_toggle;
  logic                tick, rise_en, fall_en;
  logic                last_fall;

  assign rise_next = rise_cnt + 1'b1;
  assign last_fall = fall_en && (rise_cnt == EDGE_W'(LAST_DATA_BIT));

  adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .run     (sck_run),
    .toggle  (sck_toggle),
    .tick    (tick),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_comb begin
    state_next = state;
    sck_run    = (state != IDLE);
    sck_toggle = (state == XFER);
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start)     state_next = SETUP;
      SETUP:   if (tick)      state_next = XFER;
      XFER:    if (last_fall) state_next = DONE;
      DONE:    if (tick)      state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Pin outputs are registered so the ADC never sees decode glitches on CS or SCK.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ch_latched <= 1'b0;
      rise_cnt   <= '0;
      shreg      <= '0;
      adc_cs     <= 1'b1;
      adc_sck    <= 1'b0;
      adc_mosi   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_next;
      adc_cs     <= !((state_next == SETUP) || (state_next == XFER));
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ch_latched <= channel;
            rise_cnt   <= '0;
            adc_mosi   <= frame_bit(EDGE_W'(1), channel);
          end
        end
        XFER: begin
          if (rise_en) begin
            adc_sck  <= 1'b1;
            rise_cnt <= rise_next;
            if (rise_next >= EDGE_W'(FIRST_DATA_BIT) && rise_next <= EDGE_W'(LAST_DATA_BIT))
              shreg <= {shreg[DATA_W-2:0], adc_miso};
          end
          // After falling edge n the line carries frame bit n+1 (zero beyond the frame).
          if (fall_en) begin
            adc_sck  <= 1'b0;
            adc_mosi <= frame_bit(rise_next, ch_latched);
          end
          if (last_fall) begin
            data_out   <= shreg;
            data_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Self-checking bench for adc_spi_sampler with a small MCP3002-style ADC model.
module tb_adc_spi_sampler;

  localparam int SCK_DIV = 4;
  localparam int LATENCY = 33 * SCK_DIV + 1;
  localparam int PERIOD  = 34 * SCK_DIV + 1;

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       channel;
  logic       adc_cs;
  logic       adc_sck;
  logic       adc_mosi;
  logic       adc_miso = 1'b0;
  logic [9:0] data_out;
  logic       data_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ch;
    logic [9:0]  value;
    logic [15:0] exp_cmd;
    logic [9:0]  exp_data;
  } vec_t;

  vec_t vecs [3];

  always #5 sysclk = ~sysclk;

  adc_spi_sampler #(.SCK_DIV(SCK_DIV)) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .start      (start),
    .channel    (channel),
    .adc_cs     (adc_cs),
    .adc_sck    (adc_sck),
    .adc_mosi   (adc_mosi),
    .adc_miso   (adc_miso),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  // ADC model: one queued sample per CS-low frame, result bits B9..B0 after falls 6..15.
  logic [9:0]  adc_queue [$];
  logic [9:0]  adc_value = '0;
  logic [15:0] mosi_seen = '0;
  int          rise_seen = 0;
  int          fall_seen = 0;
  logic        prev_cs   = 1'b1;
  logic        prev_sck  = 1'b0;

  always begin
    @(posedge sysclk);
    #2;
    if (prev_cs && !adc_cs) begin
      adc_value = (adc_queue.size() > 0) ? adc_queue.pop_front() : 10'h000;
      mosi_seen = '0;
      rise_seen = 0;
      fall_seen = 0;
      adc_miso  = 1'b0;
    end
    if (!prev_sck && adc_sck) begin
      mosi_seen = {mosi_seen[14:0], adc_mosi};
      rise_seen++;
    end
    if (prev_sck && !adc_sck && !adc_cs) begin
      fall_seen++;
      if (fall_seen >= 6 && fall_seen <= 15) adc_miso = adc_value[4'(15 - fall_seen)];
      else                                   adc_miso = 1'b0;
    end
    if (adc_cs) adc_miso = 1'b0;
    prev_cs  = adc_cs;
    prev_sck = adc_sck;
  end

  function automatic logic [15:0] expected_cmd(input logic ch);
    return {1'b1, 1'b1, ch, 1'b1, 12'h000};
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    for (n = 0; n < 4 * SCK_DIV && busy; n++) tick();
    checkOutput({tag, "_idle_busy"}, int'(busy), 0);
    checkOutput({tag, "_idle_cs"}, int'(adc_cs), 1);
  endtask

  // One frame from an IDLE start; the channel input is flipped right after so only the latched value counts.
  task automatic applyStimulus(input logic ch, input logic [9:0] value,
                               input logic [15:0] exp_cmd, input logic [9:0] exp_data,
                               input string tag);
    int         n;
    bit         seen;
    bit         stable;
    logic [9:0] held;
    adc_queue.push_back(value);
    held    = data_out;
    stable  = 1'b1;
    seen    = 1'b0;
    channel = ch;
    start   = 1'b1;
    for (n = 1; n <= LATENCY + 50; n++) begin
      tick();
      if (n == 1) begin
        start   = 1'b0;
        channel = ~ch;
      end
      if (data_valid) begin
        seen = 1'b1;
        break;
      end
      if (data_out !== held) stable = 1'b0;
    end
    checkOutput({tag, "_latency"}, seen ? n : -1, LATENCY);
    checkOutput({tag, "_data"}, int'(data_out), int'(exp_data));
    checkOutput({tag, "_mosi"}, int'(mosi_seen), int'(exp_cmd));
    checkOutput({tag, "_rises"}, rise_seen, 16);
    checkOutput({tag, "_held"}, int'(stable), 1);
    tick();
    checkOutput({tag, "_valid_width"}, int'(data_valid), 0);
    checkOutput({tag, "_data_hold"}, int'(data_out), int'(exp_data));
    waitIdle(tag);
  endtask

  initial begin
    int dv_cnt;
    int dv_at;
    int gap;
    int dv_time [2];
    int dv_data [2];
    int dv_rise [2];
    logic       rch;
    logic [9:0] rval;

    vecs[0] = '{ch: 1'b0, value: 10'h2A5, exp_cmd: 16'hD000, exp_data: 10'h2A5};
    vecs[1] = '{ch: 1'b1, value: 10'h3FF, exp_cmd: 16'hF000, exp_data: 10'h3FF};
    vecs[2] = '{ch: 1'b1, value: 10'h000, exp_cmd: 16'hF000, exp_data: 10'h000};

    reset_n = 1'b0;
    start   = 1'b0;
    channel = 1'b0;
    repeat (3) tick();
    checkOutput("reset_cs", int'(adc_cs), 1);
    checkOutput("reset_sck", int'(adc_sck), 0);
    checkOutput("reset_mosi", int'(adc_mosi), 0);
    checkOutput("reset_data", int'(data_out), 0);
    checkOutput("reset_valid", int'(data_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++)
      applyStimulus(vecs[i].ch, vecs[i].value, vecs[i].exp_cmd, vecs[i].exp_data,
                    $sformatf("vec%0d", i));

    // Starts during XFER and DONE must be dropped, not queued.
    adc_queue.push_back(10'h0F0);
    dv_cnt = 0;
    dv_at  = -1;
    channel = 1'b0;
    for (int n = 0; n < 2 * PERIOD + 20; n++) begin
      start = (n == 0 || n == 10 || n == 135);
      tick();
      if (data_valid) begin
        dv_cnt++;
        dv_at = n + 1;
      end
    end
    start = 1'b0;
    checkOutput("ignore_frames", dv_cnt, 1);
    checkOutput("ignore_latency", dv_at, LATENCY);
    checkOutput("ignore_data", int'(data_out), 10'h0F0);
    checkOutput("ignore_busy", int'(busy), 0);
    applyStimulus(1'b0, 10'h1A5, expected_cmd(1'b0), 10'h1A5, "after_ignore");

    // Abort a frame 60 cycles into XFER.
    adc_queue.push_back(10'h1C3);
    dv_cnt  = 0;
    channel = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < SCK_DIV + 60; n++) begin
      tick();
      if (data_valid) dv_cnt++;
    end
    reset_n = 1'b0;
    tick();
    checkOutput("abort_cs", int'(adc_cs), 1);
    checkOutput("abort_sck", int'(adc_sck), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_data", int'(data_out), 0);
    checkOutput("abort_valid", int'(data_valid), 0);
    reset_n = 1'b1;
    for (int n = 0; n < 2 * PERIOD; n++) begin
      tick();
      if (data_valid) dv_cnt++;
    end
    checkOutput("abort_no_valid", dv_cnt, 0);
    applyStimulus(1'b0, 10'h2DB, expected_cmd(1'b0), 10'h2DB, "after_abort");

    // Start held high: two frames back to back.
    adc_queue.push_back(10'h155);
    adc_queue.push_back(10'h0AA);
    dv_cnt  = 0;
    gap     = 0;
    channel = 1'b1;
    start   = 1'b1;
    for (int n = 1; n <= 3 * PERIOD && dv_cnt < 2; n++) begin
      tick();
      if (data_valid) begin
        dv_time[dv_cnt] = n;
        dv_data[dv_cnt] = int'(data_out);
        dv_rise[dv_cnt] = rise_seen;
        dv_cnt++;
        if (dv_cnt == 2) start = 1'b0;
      end
      if (dv_cnt == 1 && adc_cs) gap++;
    end
    start = 1'b0;
    checkOutput("b2b_frames", dv_cnt, 2);
    if (dv_cnt == 2) begin
      checkOutput("b2b_latency", dv_time[0], LATENCY);
      checkOutput("b2b_period", dv_time[1] - dv_time[0], PERIOD);
      checkOutput("b2b_data0", dv_data[0], 10'h155);
      checkOutput("b2b_data1", dv_data[1], 10'h0AA);
      checkOutput("b2b_rises0", dv_rise[0], 16);
      checkOutput("b2b_rises1", dv_rise[1], 16);
      checkOutput("b2b_cs_high_min", int'(gap >= SCK_DIV), 1);
    end
    waitIdle("b2b");

    for (int i = 0; i < 6; i++) begin
      rch  = 1'($urandom_range(0, 1));
      rval = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 15)) tick();
      applyStimulus(rch, rval, expected_cmd(rch), rval, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
